// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam int PORT_CPU = 0;
   localparam int PORT_DMA = 1;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; ports in excl are not eligible this cycle.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   input  logic [1:0] excl,
   output logic       winner,
   output logic       valid,
   output logic       both
);

   logic [1:0] elig;

   always_comb begin
      elig   = req & ~excl;
      valid  = |elig;
      both   = &elig;
      winner = both ? rr_ptr : elig[1];
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between CPU (port 0) and DMA (port 1).
// Define MEM_ARB_LOCK_EN to enable locked bursts of up to MAX_BURST grants.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic          arb_clk,
   input  logic          arb_rst_n,
   input  logic [1:0]    req,
   input  logic [1:0]    we,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   input  logic [1:0]    lock,
   output logic [1:0]    gnt,
   output logic [1:0]    rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   output logic          ram_en,
   input  logic [DW-1:0] ram_rdata
);

   arb_state_e    state, state_n;
   logic          rr_ptr, rr_ptr_n;
   logic          we_q;
   logic [DW-1:0] rdata_q;
   logic          pick_win, pick_vld, pick_both;
   logic          owner, hold, rel_own, win, win_vld;

`ifdef MEM_ARB_LOCK_EN
   localparam logic [3:0] CAP = 4'(MAX_BURST - 1);
   logic [3:0] burst_cnt;
`else
   logic unused_lock;
   assign unused_lock = ^lock;
`endif

   // The port granted this cycle is excluded: its request is being consumed.
   rr_pick2 u_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .excl   (gnt),
      .winner (pick_win),
      .valid  (pick_vld),
      .both   (pick_both)
   );

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      owner   = (state == OWN1);
      hold    = 1'b0;
      rel_own = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      if (state != IDLE && lock[owner] && req[owner] && burst_cnt < CAP)
         hold = 1'b1;
      else if (state != IDLE && burst_cnt != 4'd0)
         rel_own = 1'b1;
`endif
      win      = hold ? owner : pick_win;
      win_vld  = hold | pick_vld;
      state_n  = IDLE;
      if (win_vld)
         state_n = win ? OWN1 : OWN0;
      rr_ptr_n = rr_ptr;
      if (rel_own)
         rr_ptr_n = ~owner;
      if (!hold && pick_both)
         rr_ptr_n = ~pick_win;
   end

   always_comb begin
      gnt    = 2'b00;
      ram_en = 1'b0;
      case (state)
         OWN0:    begin gnt = 2'b01; ram_en = 1'b1; end
         OWN1:    begin gnt = 2'b10; ram_en = 1'b1; end
         default: begin gnt = 2'b00; ram_en = 1'b0; end
      endcase
      ram_we = ram_en & we_q;
   end

`ifdef MEM_ARB_LOCK_EN
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n)
         burst_cnt <= 4'd0;
      else if (hold)
         burst_cnt <= burst_cnt + 4'd1;
      else
         burst_cnt <= 4'd0;
   end
`endif

   // Bus address/data hold their last values while idle.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         we_q      <= 1'b0;
      end else if (win_vld) begin
         ram_addr  <= win ? addr1  : addr0;
         ram_wdata <= win ? wdata1 : wdata0;
         we_q      <= win ? we[PORT_DMA] : we[PORT_CPU];
      end
   end

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         rvalid  <= 2'b00;
         rdata_q <= '0;
      end else begin
         rvalid <= gnt & {2{~ram_we}};
         if (|rvalid)
            rdata_q <= ram_rdata;
      end
   end

   // RAM data arrives in the rvalid cycle; the capture register holds it afterwards.
   assign rdata = (|rvalid) ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

   logic       arb_clk = 1'b0;
   logic       arb_rst_n;
   logic [1:0] req, we, lock, gnt, rvalid;
   logic [7:0] addr0, addr1, wdata0, wdata1, rdata;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;
   logic       ram_we, ram_en;
   logic [7:0] mem [256];
   logic [1:0] exp_lock [6];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 arb_clk = ~arb_clk;

   mem_arbiter #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
      .arb_clk   (arb_clk),
      .arb_rst_n (arb_rst_n),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .lock      (lock),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_en    (ram_en),
      .ram_rdata (ram_rdata)
   );

   // Synchronous RAM, preloaded while reset is low.
   always @(posedge arb_clk) begin
      if (!arb_rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h3C] <= 8'hA5;
         ram_rdata  <= 8'h00;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic tick();
      @(posedge arb_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef MEM_ARB_LOCK_EN
      exp_lock = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
`else
      exp_lock = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`endif
      arb_rst_n = 1'b0;
      req = 2'b11; we = 2'b00; lock = 2'b00;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

      // Reset holds everything quiet even with both ports requesting.
      tick(); tick();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_en", ram_en, 1'b0);
      chk("rst_we", ram_we, 1'b0);
      chk("rst_rvalid", rvalid, 2'b00);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_addr", ram_addr, 8'h00);
      arb_rst_n = 1'b1;
      tick();
      chk("first_gnt_port0", gnt, 2'b01);
      req = 2'b00;
      tick(); tick();
      chk("idle_en", ram_en, 1'b0);

      // Both ports requesting, rr pointer now favouring port 1, port 1 locked.
      req = 2'b11; lock = 2'b10;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("lock_gnt%0d", i), gnt, exp_lock[i]);
      end
      req = 2'b00; lock = 2'b00;
      tick(); tick(); tick();

      // Contention with writes: strict alternation starting at port 0.
      req = 2'b11; we = 2'b11;
      addr0 = 8'h10; wdata0 = 8'h11; addr1 = 8'h20; wdata1 = 8'h22;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("cont_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("cont_addr%0d", i), ram_addr, (i % 2 == 0) ? 8'h10 : 8'h20);
         chk($sformatf("cont_we%0d", i), ram_we, 1'b1);
      end
      req = 2'b00; we = 2'b00;
      tick();
      chk("cont_no_rvalid", rvalid, 2'b00);
      tick();
      chk("mem_10", mem[8'h10], 8'h11);
      chk("mem_20", mem[8'h20], 8'h22);

      // Single read by port 0.
      req = 2'b01; addr0 = 8'h3C;
      tick();
      chk("rd0_gnt", gnt, 2'b01);
      chk("rd0_addr", ram_addr, 8'h3C);
      chk("rd0_we", ram_we, 1'b0);
      req = 2'b00;
      tick();
      chk("rd0_rvalid", rvalid, 2'b01);
      chk("rd0_rdata", rdata, 8'hA5);
      tick();
      chk("rd0_rvalid_pulse", rvalid, 2'b00);
      chk("rd0_rdata_hold", rdata, 8'hA5);

      // Port 1 write then read of the same address.
      req = 2'b10; we = 2'b10; addr1 = 8'h80; wdata1 = 8'h5A;
      tick();
      chk("wr1_gnt", gnt, 2'b10);
      chk("wr1_we", ram_we, 1'b1);
      chk("wr1_wdata", ram_wdata, 8'h5A);
      req = 2'b00; we = 2'b00;
      tick();
      chk("wr1_no_rvalid", rvalid, 2'b00);
      req = 2'b10;
      tick();
      chk("rd1_gnt", gnt, 2'b10);
      chk("rd1_we", ram_we, 1'b0);
      req = 2'b00;
      tick();
      chk("rd1_rvalid", rvalid, 2'b10);
      chk("rd1_rdata", rdata, 8'h5A);

      // Reset in the grant cycle of a read drops it.
      tick();
      req = 2'b01; addr0 = 8'h3C;
      tick();
      chk("rstmid_gnt", gnt, 2'b01);
      arb_rst_n = 1'b0;
      req = 2'b00;
      #1;
      chk("rstmid_gnt0", gnt, 2'b00);
      chk("rstmid_en", ram_en, 1'b0);
      chk("rstmid_addr", ram_addr, 8'h00);
      chk("rstmid_rdata", rdata, 8'h00);
      tick();
      chk("rstmid_rvalid", rvalid, 2'b00);
      arb_rst_n = 1'b1;
      tick();
      chk("rstmid_rvalid_after", rvalid, 2'b00);
      chk("rstmid_gnt_after", gnt, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
